prf_read_arbiter: RTL and testbench
===================================

// Module: prf_read_arbiter
// PURPOSE
//  Schedules the PRF_RR_COUNT physical-register read requesters onto the PRF_BANK_COUNT single-read-port PRF banks.
//  Bank = pr[LOG_PRF_BANK_COUNT-1:0]; each bank serves one read per cycle.
//  Per-bank round-robin priority bounds starvation.
//  Sits between IQ issue/operand collection and the banked PRF SRAMs.
// PARAMETERS
//  PRF_RR_COUNT        11   read requesters (core_types_pkg)
//  PRF_BANK_COUNT      4    PRF banks, power of 2
//  LOG_PRF_BANK_COUNT  2    bank select width
//  LOG_PR_COUNT        7    physical register tag width
// PORTS
//  CLK                        in   1                      clock
//  RST                        in   1                      sync active-high reset
//  req_valid_by_rr            in   [RR]                   read request valid
//  req_pr_by_rr               in   [RR][LOG_PR_COUNT]     requested PR tag
//  req_ready_by_rr            out  [RR]                   comb grant; handshake done when valid&ready
//  bank_read_valid_by_bank    out  [BANK]                 registered bank read enable
//  bank_read_index_by_bank    out  [BANK][LOG_PR-LOG_BANK]  registered bank row = pr[MSBs]
//  issued_valid_by_rr         out  [RR]                   registered: this rr's read issues this cycle
//  issued_bank_by_rr          out  [RR][LOG_BANK]         registered bank carrying that read
// BEHAVIOUR
//  - Cycle N, comb: for each bank b, candidates = rr with valid & pr[1:0]==b.
//    Winner = first candidate scanning rr = ptr[b], ptr[b]+1, ... wrapping mod PRF_RR_COUNT.
//    req_ready_by_rr[winner]=1.
//  - ready does not depend on ready of other rr. A requester holds valid and pr stable until ready.
//    Dropping valid without ready is legal (operand squash).
//  - Cycle N+1, regs: bank_read_valid[b]=1, bank_read_index[b]=winner pr >> LOG_BANK;
//    issued_valid[winner]=1, issued_bank[winner]=b. Bank data is returned by the PRF at N+2 (outside this block).
//  - Pointer: ptr[b] <= (winner+1 == PRF_RR_COUNT) ? 0 : winner+1, only if bank b granted.
//    Non-power-of-2 wrap is explicit compare, not truncation.
//  - Each rr targets one bank, so at most one grant per rr per cycle. Up to PRF_BANK_COUNT grants per cycle.
//  - No candidates for a bank: ptr unchanged; bank_read_valid[b]=0 next cycle; index holds its previous value.
//  - Starvation bound: a held request is granted within PRF_RR_COUNT-1 cycles.
//  - Reset (sync, RST=1): ptr[*]=0; bank_read_valid=0; bank_read_index=0; issued_valid=0; issued_bank=0.
//    req_ready is forced 0 while RST=1, even with requests pending.
//    Reset mid-operation drops reads granted in the reset cycle; requesters re-request.
// CONFIGURATION
//  PRF_READ_MERGE_EN defined:
//    all candidates with pr identical to the winner's are also readied the same cycle and share the bank read.
//    issued_valid is set for each merged rr; ptr advances past the round-robin winner only.
//  PRF_READ_MERGE_EN undefined: strictly one rr per bank per cycle; duplicate PRs serialize.
// STRUCTURE
//  - Shared (core_types_pkg): PRF_RR_COUNT, PRF_BANK_COUNT, LOG_PRF_BANK_COUNT, LOG_PR_COUNT, PR_COUNT.
//  - Add typedefs to core_types_pkg:
//      pr_t = logic [LOG_PR_COUNT-1:0]
//      prf_bank_t = logic [LOG_PRF_BANK_COUNT-1:0]
//      prf_rr_idx_t = logic [$clog2(PRF_RR_COUNT)-1:0]
//  - Sub-module rr_pe_wrap: rotating-priority encoder (N requests + start ptr -> one-hot + index + found).
//    Instantiated PRF_BANK_COUNT times.
// TESTING
//  1. Post-reset, rr0 pr=0x05 and rr3 pr=0x0A, both alone in banks 1 and 2.
//     -> both ready in N; at N+1: bank1 idx 0x01, bank2 idx 0x02, issued_valid rr0 and rr3.
//  2. rr0, rr4, rr9 all hold bank-0 PRs (0x00, 0x04, 0x08) from reset.
//     -> grants rr0, rr4, rr9 on consecutive cycles; ptr0 = 1, 5, then 10.
//  3. ptr0 = 10; rr10 and rr1 request bank 0.
//     -> rr10 granted, ptr0 wraps to 0; next cycle rr1 granted, ptr0 = 2.
//  4. All 11 rr hold bank-3 requests continuously.
//     -> each granted exactly once in 11 cycles; no rr waits >10 cycles.
//  5. rr2 and rr6 both request pr=0x13.
//     -> MERGE_EN: both ready same cycle, single bank3 read idx 0x04.
//     -> MERGE off: rr2 then rr6 on consecutive cycles.
//  6. RST=1 in the cycle rr5 requests pr=0x01.
//     -> ready 0; at N+1 all outputs 0 and ptrs 0; after RST drops, rr5 granted.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared core types: requester/bank counts, PR tag types, and the non-power-of-2
// round-robin pointer increment used by the PRF read arbiter.
package core_types_pkg;

  localparam int unsigned PRF_RR_COUNT       = 11;
  localparam int unsigned PRF_BANK_COUNT     = 4;
  localparam int unsigned LOG_PRF_BANK_COUNT = 2;
  localparam int unsigned LOG_PR_COUNT       = 7;
  localparam int unsigned PR_COUNT           = 1 << LOG_PR_COUNT;
  localparam int unsigned LOG_PRF_RR_COUNT   = $clog2(PRF_RR_COUNT);
  localparam int unsigned PRF_ROW_W          = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  typedef logic [LOG_PR_COUNT-1:0]       pr_t;
  typedef logic [LOG_PRF_BANK_COUNT-1:0] prf_bank_t;
  typedef logic [LOG_PRF_RR_COUNT-1:0]   prf_rr_idx_t;
  typedef logic [PRF_ROW_W-1:0]          prf_row_t;

  // Wrap by explicit compare: PRF_RR_COUNT is not a power of two.
  function automatic prf_rr_idx_t rr_ptr_next(prf_rr_idx_t idx);
    if (32'(idx) + 32'd1 == PRF_RR_COUNT) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pe_wrap.sv
// Rotating-priority encoder: first set request scanning from start upward,
// wrapping modulo N. Produces one-hot grant, winner index and a found flag.
module rr_pe_wrap #(
  parameter int unsigned N     = 11,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = start;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[pos]) begin
        found      = 1'b1;
        idx        = pos;
        grant[pos] = 1'b1;
      end
      pos = (32'(pos) + 32'd1 == N) ? '0 : pos + 1'b1;
    end
  end

endmodule

// File: rtl/prf_read_arbiter.sv
// Schedules PRF read requesters onto single-read-port PRF banks with per-bank
// round-robin priority. Optional feature: PRF_READ_MERGE_EN (same-PR read sharing).
module prf_read_arbiter
  import core_types_pkg::*;
(
  input  logic                                              CLK,
  input  logic                                              RST,
  input  logic [PRF_RR_COUNT-1:0]                           req_valid_by_rr,
  input  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0]         req_pr_by_rr,
  output logic [PRF_RR_COUNT-1:0]                           req_ready_by_rr,
  output logic [PRF_BANK_COUNT-1:0]                         bank_read_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][PRF_ROW_W-1:0]          bank_read_index_by_bank,
  output logic [PRF_RR_COUNT-1:0]                           issued_valid_by_rr,
  output logic [PRF_RR_COUNT-1:0][LOG_PRF_BANK_COUNT-1:0]   issued_bank_by_rr
);

  logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0] cand;
  logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0] pe_grant;
  prf_rr_idx_t [PRF_BANK_COUNT-1:0]            ptr_q, ptr_d, win_idx;
  logic [PRF_BANK_COUNT-1:0]                   win_found;
  pr_t [PRF_BANK_COUNT-1:0]                    win_pr;
  logic [PRF_RR_COUNT-1:0]                     ready;

  always_comb begin
    cand = '0;
    for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int unsigned r = 0; r < PRF_RR_COUNT; r++) begin
        cand[b][r] = req_valid_by_rr[r] &&
                     (req_pr_by_rr[r][LOG_PRF_BANK_COUNT-1:0] == prf_bank_t'(b));
      end
    end
  end

  for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
    rr_pe_wrap #(
      .N     (PRF_RR_COUNT),
      .IDX_W (LOG_PRF_RR_COUNT)
    ) u_pe (
      .req   (cand[b]),
      .start (ptr_q[b]),
      .grant (pe_grant[b]),
      .idx   (win_idx[b]),
      .found (win_found[b])
    );
  end

  always_comb begin
    ready  = '0;
    win_pr = '0;
    ptr_d  = ptr_q;
    for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) begin
      win_pr[b] = req_pr_by_rr[win_idx[b]];
      ready     = ready | pe_grant[b];
`ifdef PRF_READ_MERGE_EN
      // Same-PR candidates piggyback on the winner's bank read; pointer still
      // advances past the round-robin winner only.
      for (int unsigned r = 0; r < PRF_RR_COUNT; r++) begin
        if (win_found[b] && cand[b][r] && (req_pr_by_rr[r] == win_pr[b])) begin
          ready[r] = 1'b1;
        end
      end
`endif
      if (win_found[b]) begin
        ptr_d[b] = rr_ptr_next(win_idx[b]);
      end
    end
    if (RST) begin
      ready = '0;
    end
  end

  assign req_ready_by_rr = ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q                   <= '0;
      bank_read_valid_by_bank <= '0;
      bank_read_index_by_bank <= '0;
      issued_valid_by_rr      <= '0;
      issued_bank_by_rr       <= '0;
    end else begin
      ptr_q                   <= ptr_d;
      bank_read_valid_by_bank <= win_found;
      issued_valid_by_rr      <= ready;
      for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) begin
        // Idle banks keep their last row index.
        if (win_found[b]) begin
          bank_read_index_by_bank[b] <= win_pr[b][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
        end
      end
      for (int unsigned r = 0; r < PRF_RR_COUNT; r++) begin
        if (ready[r]) begin
          issued_bank_by_rr[r] <= req_pr_by_rr[r][LOG_PRF_BANK_COUNT-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_read_arbiter.sv
// Directed table-driven bench for prf_read_arbiter; expectations follow
// PRF_READ_MERGE_EN when that macro is defined.
module tb_prf_read_arbiter;
  import core_types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [10:0]       valid;
  logic [10:0][6:0]  pr;
  logic [10:0]       ready;
  logic [3:0]        bvalid;
  logic [3:0][4:0]   bidx;
  logic [10:0]       issued;
  logic [10:0][1:0]  ibank;

  prf_read_arbiter dut (
    .CLK                     (clk),
    .RST                     (rst),
    .req_valid_by_rr         (valid),
    .req_pr_by_rr            (pr),
    .req_ready_by_rr         (ready),
    .bank_read_valid_by_bank (bvalid),
    .bank_read_index_by_bank (bidx),
    .issued_valid_by_rr      (issued),
    .issued_bank_by_rr       (ibank)
  );

  typedef struct {
    logic             rst;
    logic [10:0]      valid;
    logic [10:0][6:0] pr;
    logic [10:0]      ready;     // comb, same cycle
    logic [3:0]       bvalid;    // registered, next cycle
    logic [3:0]       idx_mask;
    logic [3:0][4:0]  idx;
    logic [10:0]      issued;
    logic [10:0][1:0] ibank;
  } vec_t;

  vec_t tbl[$];
  vec_t v;
  int   checks = 0;
  int   errors = 0;

  task automatic clr();
    v.rst = 1'b0; v.valid = '0; v.pr = '0; v.ready = '0; v.bvalid = '0;
    v.idx_mask = '0; v.idx = '0; v.issued = '0; v.ibank = '0;
  endtask

  task automatic check(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    valid = '0;
    pr    = '0;

    // Reset
    clr(); v.rst = 1'b1; v.idx_mask = 4'hF; tbl.push_back(v);
    // Two lone requesters in banks 1 and 2
    clr(); v.valid = 11'h009; v.pr[0] = 7'h05; v.pr[3] = 7'h0A; v.ready = 11'h009;
    v.bvalid = 4'b0110; v.idx_mask = 4'b0110; v.idx[1] = 5'd1; v.idx[2] = 5'd2;
    v.issued = 11'h009; v.ibank[0] = 2'd1; v.ibank[3] = 2'd2; tbl.push_back(v);
    // Bank 0 contention rr0, rr4, rr9; bank1 index must hold
    clr(); v.valid = 11'h211; v.pr[0] = 7'h00; v.pr[4] = 7'h04; v.pr[9] = 7'h08;
    v.ready = 11'h001; v.bvalid = 4'b0001; v.idx_mask = 4'b0011; v.idx[0] = 5'd0;
    v.idx[1] = 5'd1; v.issued = 11'h001; v.ibank[0] = 2'd0; tbl.push_back(v);
    clr(); v.valid = 11'h210; v.pr[4] = 7'h04; v.pr[9] = 7'h08; v.ready = 11'h010;
    v.bvalid = 4'b0001; v.idx_mask = 4'b0001; v.idx[0] = 5'd1; v.issued = 11'h010;
    tbl.push_back(v);
    clr(); v.valid = 11'h200; v.pr[9] = 7'h08; v.ready = 11'h200;
    v.bvalid = 4'b0001; v.idx_mask = 4'b0001; v.idx[0] = 5'd2; v.issued = 11'h200;
    tbl.push_back(v);
    // ptr0 = 10: rr10 beats rr1, then wrap
    clr(); v.valid = 11'h402; v.pr[10] = 7'h0C; v.pr[1] = 7'h10; v.ready = 11'h400;
    v.bvalid = 4'b0001; v.idx_mask = 4'b0001; v.idx[0] = 5'd3; v.issued = 11'h400;
    tbl.push_back(v);
    clr(); v.valid = 11'h002; v.pr[1] = 7'h10; v.ready = 11'h002;
    v.bvalid = 4'b0001; v.idx_mask = 4'b0001; v.idx[0] = 5'd4; v.issued = 11'h002;
    tbl.push_back(v);
    // ptr0 = 2: rr2 beats rr1
    clr(); v.valid = 11'h006; v.pr[1] = 7'h14; v.pr[2] = 7'h18; v.ready = 11'h004;
    v.bvalid = 4'b0001; v.idx_mask = 4'b0001; v.idx[0] = 5'd6; v.issued = 11'h004;
    tbl.push_back(v);
    clr(); v.valid = 11'h002; v.pr[1] = 7'h14; v.ready = 11'h002;
    v.bvalid = 4'b0001; v.idx_mask = 4'b0001; v.idx[0] = 5'd5; v.issued = 11'h002;
    tbl.push_back(v);
    // All 11 on bank 3: strict rotation, each granted once in 11 cycles
    for (int r = 0; r < 11; r++) begin
      clr();
      v.valid = 11'h7FF & ~((11'd1 << r) - 11'd1);
      for (int k = 0; k < 11; k++) v.pr[k] = 7'(k * 4 + 3);
      v.ready = 11'd1 << r; v.bvalid = 4'b1000; v.idx_mask = 4'b1000;
      v.idx[3] = 5'(r); v.issued = 11'd1 << r; v.ibank[r] = 2'd3;
      tbl.push_back(v);
    end
    // Duplicate PR 0x13 from rr2 and rr6
`ifdef PRF_READ_MERGE_EN
    clr(); v.valid = 11'h044; v.pr[2] = 7'h13; v.pr[6] = 7'h13; v.ready = 11'h044;
    v.bvalid = 4'b1000; v.idx_mask = 4'b1000; v.idx[3] = 5'd4; v.issued = 11'h044;
    v.ibank[2] = 2'd3; v.ibank[6] = 2'd3; tbl.push_back(v);
`else
    clr(); v.valid = 11'h044; v.pr[2] = 7'h13; v.pr[6] = 7'h13; v.ready = 11'h004;
    v.bvalid = 4'b1000; v.idx_mask = 4'b1000; v.idx[3] = 5'd4; v.issued = 11'h004;
    v.ibank[2] = 2'd3; tbl.push_back(v);
    clr(); v.valid = 11'h040; v.pr[6] = 7'h13; v.ready = 11'h040;
    v.bvalid = 4'b1000; v.idx_mask = 4'b1000; v.idx[3] = 5'd4; v.issued = 11'h040;
    v.ibank[6] = 2'd3; tbl.push_back(v);
`endif
    // Reset while rr5 requests: no ready, everything cleared
    clr(); v.rst = 1'b1; v.valid = 11'h020; v.pr[5] = 7'h01; v.idx_mask = 4'hF;
    tbl.push_back(v);
    // ptr1 back at 0: rr0 beats rr5, then rr5
    clr(); v.valid = 11'h021; v.pr[0] = 7'h05; v.pr[5] = 7'h01; v.ready = 11'h001;
    v.bvalid = 4'b0010; v.idx_mask = 4'b0010; v.idx[1] = 5'd1; v.issued = 11'h001;
    v.ibank[0] = 2'd1; tbl.push_back(v);
    clr(); v.valid = 11'h020; v.pr[5] = 7'h01; v.ready = 11'h020;
    v.bvalid = 4'b0010; v.idx_mask = 4'b0010; v.idx[1] = 5'd0; v.issued = 11'h020;
    v.ibank[5] = 2'd1; tbl.push_back(v);
    // All four banks in one cycle
    clr(); v.valid = 11'h00F; v.pr[0] = 7'h00; v.pr[1] = 7'h01; v.pr[2] = 7'h02;
    v.pr[3] = 7'h03; v.ready = 11'h00F; v.bvalid = 4'hF; v.idx_mask = 4'hF;
    v.issued = 11'h00F; v.ibank[1] = 2'd1; v.ibank[2] = 2'd2; v.ibank[3] = 2'd3;
    tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst   = tbl[i].rst;
      valid = tbl[i].valid;
      pr    = tbl[i].pr;
      #1;
      check("req_ready", i, 64'(ready), 64'(tbl[i].ready));
      @(posedge clk);
      #1;
      check("bank_read_valid", i, 64'(bvalid), 64'(tbl[i].bvalid));
      check("issued_valid", i, 64'(issued), 64'(tbl[i].issued));
      for (int b = 0; b < 4; b++) begin
        if (tbl[i].idx_mask[b]) check("bank_read_index", i, 64'(bidx[b]), 64'(tbl[i].idx[b]));
      end
      for (int r = 0; r < 11; r++) begin
        if (tbl[i].issued[r] || tbl[i].rst) begin
          check("issued_bank", i, 64'(ibank[r]), 64'(tbl[i].ibank[r]));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
